// File: rtl/cfs_algn_pkg.sv
// cfs_algn_pkg: aligner widths, FIFO entry field positions and sequencer states
package cfs_algn_pkg;
   localparam int ALGN_DATA_WIDTH = 32;
   localparam int BYTES = ALGN_DATA_WIDTH / 8;
   function automatic int offset_w(int b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction
   function automatic int size_w(int b);
      return $clog2(b) + 1;
   endfunction
   function automatic int cnt_w(int b);
      return $clog2(2 * b) + 1;
   endfunction
   localparam int ALGN_OFFSET_WIDTH = offset_w(BYTES);
   localparam int ALGN_SIZE_WIDTH = size_w(BYTES);
   localparam int CNT_WIDTH = cnt_w(BYTES);
   localparam int FIFO_DATA_WIDTH = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH;
   localparam int DATA_LSB = 0;
   localparam int DATA_MSB = ALGN_DATA_WIDTH - 1;
   localparam int OFFSET_LSB = ALGN_DATA_WIDTH;
   localparam int OFFSET_MSB = OFFSET_LSB + ALGN_OFFSET_WIDTH - 1;
   localparam int SIZE_LSB = OFFSET_MSB + 1;
   localparam int SIZE_MSB = FIFO_DATA_WIDTH - 1;
   typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
endpackage

// File: rtl/cfs_algn_ctrl_if.sv
// cfs_algn_ctrl_if: RX FIFO pop port and TX FIFO push port of the aligner sequencer
interface cfs_algn_ctrl_if
   import cfs_algn_pkg::*;
();
   logic pop_valid;
   logic pop_ready;
   logic [FIFO_DATA_WIDTH-1:0] pop_data;
   logic push_valid;
   logic push_ready;
   logic [FIFO_DATA_WIDTH-1:0] push_data;
   modport master (output pop_valid, pop_data, push_ready, input pop_ready, push_valid, push_data);
   modport slave (input pop_valid, pop_data, push_ready, output pop_ready, push_valid, push_data);
endinterface

// File: rtl/cfs_algn_byte_acc.sv
// cfs_algn_byte_acc: 2*BYTES byte accumulator, oldest byte in the LSBs
module cfs_algn_byte_acc
   import cfs_algn_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic append,
   input  logic [ALGN_DATA_WIDTH-1:0] in_bytes,
   input  logic [ALGN_OFFSET_WIDTH-1:0] in_offset,
   input  logic [ALGN_SIZE_WIDTH-1:0] in_size,
   input  logic consume,
   input  logic [ALGN_SIZE_WIDTH-1:0] cfg_size,
   output logic [ALGN_DATA_WIDTH-1:0] head,
   output logic [CNT_WIDTH-1:0] cnt
);
   localparam int AW = 2 * ALGN_DATA_WIDTH;
   logic [AW-1:0] acc;
   logic [AW-1:0] window;
   // bytes at and above cnt are always zero, so appending is an OR of the shifted window
   assign window = (AW'(in_bytes) >> {in_offset, 3'b000}) & ~({AW{1'b1}} << {in_size, 3'b000});
   assign head = acc[ALGN_DATA_WIDTH-1:0];
   always_ff @(posedge clk)
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (consume) begin
         acc <= acc >> {cfg_size, 3'b000};
         cnt <= cnt - CNT_WIDTH'(cfg_size);
      end else if (append) begin
         acc <= acc | (window << {cnt, 3'b000});
         cnt <= cnt + CNT_WIDTH'(in_size);
      end
endmodule

// File: rtl/cfs_algn_ctrl.sv
// cfs_algn_ctrl: pops unaligned RX entries, re-slices their bytes to CTRL size/offset and pushes to TX
module cfs_algn_ctrl
   import cfs_algn_pkg::*;
(
   input  logic pclk,
   input  logic preset,
   input  logic [ALGN_SIZE_WIDTH-1:0] ctrl_size,
   input  logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
   cfs_algn_ctrl_if.slave bus,
   output logic busy
);
   state_t state, nxt;
   logic [ALGN_SIZE_WIDTH-1:0] cfg_size, size_nxt;
   logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset, offset_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic [ALGN_DATA_WIDTH-1:0] head, out_data;
   logic [ALGN_SIZE_WIDTH-1:0] in_size;
   logic pop, push, hold_cfg;
   function automatic logic cfg_ok(logic [ALGN_SIZE_WIDTH-1:0] s, logic [ALGN_OFFSET_WIDTH-1:0] o);
      return s != 0 && int'(s) <= BYTES && (BYTES + int'(o)) % int'(s) == 0;
   endfunction
   assign pop = bus.pop_valid & bus.pop_ready;
   assign push = bus.push_valid & bus.push_ready;
   assign in_size = bus.pop_data[SIZE_MSB:SIZE_LSB];
   assign cnt_nxt = pop ? cnt + CNT_WIDTH'(in_size) : push ? cnt - CNT_WIDTH'(cfg_size) : cnt;
   // a pop from IDLE keeps the cfg whose validity allowed it
   assign hold_cfg = state != IDLE || pop;
   assign size_nxt = hold_cfg ? cfg_size : ctrl_size;
   assign offset_nxt = hold_cfg ? cfg_offset : ctrl_offset;
   assign nxt = !(pop || push) ? state : cnt_nxt == '0 ? IDLE : cnt_nxt < CNT_WIDTH'(cfg_size) ? FILL : EMIT;
   cfs_algn_byte_acc u_acc (
      .clk(pclk),
      .rst(preset),
      .append(pop),
      .in_bytes(bus.pop_data[DATA_MSB:DATA_LSB]),
      .in_offset(bus.pop_data[OFFSET_MSB:OFFSET_LSB]),
      .in_size(in_size),
      .consume(push),
      .cfg_size(cfg_size),
      .head(head),
      .cnt(cnt)
   );
   // IDLE is re-entered with pop_ready low so the next packet sees a freshly latched cfg
   always_ff @(posedge pclk)
      if (preset) begin
         state <= IDLE;
         cfg_size <= '0;
         cfg_offset <= '0;
         bus.pop_ready <= 1'b0;
         bus.push_valid <= 1'b0;
      end else begin
         state <= nxt;
         cfg_size <= size_nxt;
         cfg_offset <= offset_nxt;
         bus.pop_ready <= nxt == FILL || (nxt == IDLE && state == IDLE && cfg_ok(size_nxt, offset_nxt));
         bus.push_valid <= nxt == EMIT;
      end
   assign out_data = (head & ~({ALGN_DATA_WIDTH{1'b1}} << {cfg_size, 3'b000})) << {cfg_offset, 3'b000};
   assign bus.push_data = bus.push_valid ? {cfg_size, cfg_offset, out_data} : '0;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_cfs_algn_ctrl.sv
// tb_cfs_algn_ctrl: directed and randomized checks against a byte-queue model of the aligner
module tb_cfs_algn_ctrl;
   import cfs_algn_pkg::*;
   logic pclk = 1'b0;
   logic preset = 1'b1;
   logic busy;
   logic [ALGN_SIZE_WIDTH-1:0] ctrl_size = '0;
   logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset = '0;
   int checks = 0;
   int failures = 0;
   byte unsigned q[$];
   int msize = 0;
   int moff = 0;
   cfs_algn_ctrl_if bus ();
   cfs_algn_ctrl dut (
      .pclk(pclk),
      .preset(preset),
      .ctrl_size(ctrl_size),
      .ctrl_offset(ctrl_offset),
      .bus(bus),
      .busy(busy)
   );
   always #5 pclk = ~pclk;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic cyc(int n = 1);
      repeat (n) @(negedge pclk);
   endtask
   function automatic logic [FIFO_DATA_WIDTH-1:0] entry(int s, int o, logic [ALGN_DATA_WIDTH-1:0] d);
      return {ALGN_SIZE_WIDTH'(s), ALGN_OFFSET_WIDTH'(o), d};
   endfunction
   function automatic logic [FIFO_DATA_WIDTH-1:0] model_out();
      logic [ALGN_DATA_WIDTH-1:0] d;
      d = '0;
      for (int j = 0; j < msize; j++)
         if (moff + j < BYTES) d[8*(moff+j) +: 8] = q[j];
      return entry(msize, moff, d);
   endfunction
   task automatic set_cfg(int s, int o);
      ctrl_size = ALGN_SIZE_WIDTH'(s);
      ctrl_offset = ALGN_OFFSET_WIDTH'(o);
      cyc(2);
   endtask
   task automatic pop(int s, int o, logic [ALGN_DATA_WIDTH-1:0] d);
      int n;
      n = 0;
      if (q.size() == 0) begin
         msize = int'(ctrl_size);
         moff = int'(ctrl_offset);
      end
      bus.pop_valid = 1'b1;
      bus.pop_data = entry(s, o, d);
      while (!bus.pop_ready && n < 20) begin
         cyc();
         n++;
      end
      check("pop_ready", bus.pop_ready, 1);
      cyc();
      bus.pop_valid = 1'b0;
      if (n < 20)
         for (int i = 0; i < s; i++) q.push_back(d[8*(o+i) +: 8]);
   endtask
   task automatic expect_push(int stall);
      logic [FIFO_DATA_WIDTH-1:0] exp;
      int n;
      exp = model_out();
      n = 0;
      while (!bus.push_valid && n < 20) begin
         cyc();
         n++;
      end
      check("push_valid", bus.push_valid, 1);
      for (int i = 0; i < stall; i++) begin
         check("stall_data", bus.push_data, exp);
         check("stall_pop_ready", bus.pop_ready, 0);
         cyc();
         check("stall_valid", bus.push_valid, 1);
      end
      check("push_data", bus.push_data, exp);
      bus.push_ready = 1'b1;
      cyc();
      bus.push_ready = 1'b0;
      for (int j = 0; j < msize && q.size() > 0; j++) void'(q.pop_front());
   endtask
   task automatic pk(int s, int o, logic [ALGN_DATA_WIDTH-1:0] d, int stall = 0);
      pop(s, o, d);
      check("latency_push_valid", bus.push_valid, q.size() >= msize);
      while (q.size() >= msize && msize > 0) begin
         expect_push(stall);
         if (q.size() >= msize) check("between_pop_ready", bus.pop_ready, 0);
      end
      check("after_push_valid", bus.push_valid, 0);
      check("busy", busy, q.size() != 0);
   endtask
   initial begin
      int cs, co, s, o;
      bus.pop_valid = 1'b1;
      bus.pop_data = entry(4, 0, 32'h12345678);
      bus.push_ready = 1'b0;
      ctrl_size = ALGN_SIZE_WIDTH'(3);
      cyc(3);
      check("rst_pop_ready", bus.pop_ready, 0);
      check("rst_push_valid", bus.push_valid, 0);
      check("rst_push_data", bus.push_data, 0);
      check("rst_busy", busy, 0);
      preset = 1'b0;
      cyc(6);
      check("invalid_cfg_pop_ready", bus.pop_ready, 0);
      check("invalid_cfg_busy", busy, 0);
      ctrl_size = ALGN_SIZE_WIDTH'(4);
      cyc();
      check("valid_cfg_pop_ready", bus.pop_ready, 1);
      bus.pop_valid = 1'b0;
      cyc();
      pk(2, 0, 32'h0000BBAA);
      pk(2, 2, 32'hDDCC0000);
      set_cfg(2, 2);
      pk(4, 0, 32'h44332211);
      set_cfg(4, 0);
      pk(4, 0, $urandom(), 5);
      pk(1, 0, 32'h000000A1);
      ctrl_size = ALGN_SIZE_WIDTH'(2);
      ctrl_offset = ALGN_OFFSET_WIDTH'(2);
      cyc(2);
      pk(1, 1, 32'h0000B200);
      pk(1, 2, 32'h00C30000);
      pk(1, 3, 32'hD4000000);
      cyc(2);
      pk(2, 0, 32'h0000F6E5);
      set_cfg(4, 0);
      pk(1, 0, 32'h00000077);
      pk(1, 0, 32'h00000088);
      preset = 1'b1;
      cyc();
      preset = 1'b0;
      q.delete();
      check("midfill_rst_busy", busy, 0);
      check("midfill_rst_push_valid", bus.push_valid, 0);
      cyc(2);
      pk(4, 0, 32'h0D0C0B0A);
      for (int it = 0; it < 150; it++) begin
         if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
            do begin
               cs = int'($urandom_range(1, BYTES));
               co = int'($urandom_range(0, BYTES - 1));
            end while ((BYTES + co) % cs != 0);
            set_cfg(cs, co);
         end
         s = int'($urandom_range(0, BYTES));
         o = int'($urandom_range(0, BYTES - (s > 0 ? s : 1)));
         if ($urandom_range(0, 2) == 0) cyc(int'($urandom_range(1, 3)));
         pk(s, o, $urandom(), int'($urandom_range(0, 2)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
